// File: rtl/pcie_link_pkg.sv
// ============================================================================
// Module   : pcie_link_pkg
// Purpose  : Shared types and constants for the PCIe reset / link bring-up
//            sequencer. Holds the sequencer state enum, the LTSSM L0 code,
//            the default timing parameters and a small retry-count helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_link_pkg;

  // Sequencer states. The encodings are reported on o3_State, so they are fixed.
  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_HOLD     = 3'd2,
    ST_TRAIN    = 3'd3,
    ST_LINKUP   = 3'd4,
    ST_FAIL     = 3'd5
  } link_state_e;

  // HIP LTSSM encoding for L0.
  localparam logic [4:0] LTSSM_L0 = 5'h0F;

  // Default timing, in 125 MHz cycles.
  localparam int DEF_PERST_CYCLES  = 12500;     // 100 us
  localparam int DEF_TRAIN_TIMEOUT = 12500000;  // 100 ms
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRY     = 3;

  // Retry counter increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage : pcie_link_pkg

`default_nettype wire

// File: rtl/pcie_cycle_timer.sv
// ============================================================================
// Module   : pcie_cycle_timer
// Purpose  : Loadable up-counter with synchronous clear and a terminal-count
//            flag. The flag is combinational: it is high while the count equals
//            i_TermVal.
// Ports    : i_Clk, i_Rst (async, active-high)
//            i_Clr     - force count to zero on the next edge (highest priority)
//            i_Load    - load i_LoadVal on the next edge
//            i_LoadVal - value used by i_Load
//            i_En      - increment on the next edge
//            i_TermVal - terminal-count compare value
//            o_Tc      - count == i_TermVal
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Clr,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_LoadVal,
  input  logic             i_En,
  input  logic [WIDTH-1:0] i_TermVal,
  output logic             o_Tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_Clr) begin
      count_d = '0;
    end else if (i_Load) begin
      count_d = i_LoadVal;
    end else if (i_En) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Tc = (count_q == i_TermVal);

endmodule : pcie_cycle_timer

`default_nettype wire

// File: rtl/pcie_link_ctrl.sv
// ============================================================================
// Module   : pcie_link_ctrl
// Purpose  : Reset and link bring-up sequencer for the PCIe hard IP. Orders
//            npor / pin_perst / application reset release after PLL lock,
//            watches the LTSSM for a stable L0, retries training on timeout
//            and reports link-up or failure.
// Ports    : i_Clk125M    - sole clock
//            i_Rst        - asynchronous active-high reset
//            i_PllLocked  - reference / transceiver PLL locked
//            i_PerstReq   - one-cycle request for a full re-sequence
//            i5_Ltssm     - HIP LTSSM state
//            o_Npor_L     - HIP npor
//            o_PinPerst_L - HIP pin_perst
//            o_AppRst_L   - design-example reset_n
//            o_LinkUp     - link trained and stable
//            o_Fail       - training retries exhausted
//            o3_State     - current state encoding
//            o4_RetryCnt  - training timeouts since the last sequence start
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_link_ctrl
  import pcie_link_pkg::*;
#(
  parameter int PERST_CYCLES  = DEF_PERST_CYCLES,
  parameter int TRAIN_TIMEOUT = DEF_TRAIN_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       i_Clk125M,
  input  logic       i_Rst,
  input  logic       i_PllLocked,
  input  logic       i_PerstReq,
  input  logic [4:0] i5_Ltssm,
  output logic       o_Npor_L,
  output logic       o_PinPerst_L,
  output logic       o_AppRst_L,
  output logic       o_LinkUp,
  output logic       o_Fail,
  output logic [2:0] o3_State,
  output logic [3:0] o4_RetryCnt
);

  // HOLD and TRAIN never overlap, so one counter serves both; it is sized
  // for whichever of the two limits needs more bits.
  localparam int c_HoldW = $clog2(PERST_CYCLES) + 1;
  localparam int c_TmoW  = $clog2(TRAIN_TIMEOUT) + 1;
  localparam int c_TmrW  = (c_TmoW > c_HoldW) ? c_TmoW : c_HoldW;
  localparam int c_SetW  = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [c_TmrW-1:0] c_HoldTerm  = c_TmrW'(PERST_CYCLES - 1);
  localparam logic [c_TmrW-1:0] c_TmoTerm   = c_TmrW'(TRAIN_TIMEOUT - 1);
  localparam logic [c_SetW-1:0] c_SetTerm   = c_SetW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]        c_RetryLast = 4'(MAX_RETRY - 1);

  link_state_e       state_q, state_d;
  logic [3:0]        retry_q, retry_d;
  logic              npor_q, npor_d;
  logic              perst_q, perst_d;
  logic              app_q, app_d;
  logic              linkup_q, linkup_d;
  logic              fail_q, fail_d;

  logic              w_L0;
  logic              w_PerstTake;
  logic              w_TmrClr;
  logic              w_TmrEn;
  logic              w_TmrTc;
  logic [c_TmrW-1:0] w_TmrTerm;
  logic              w_SetRun;
  logic              w_SetTc;
  logic              w_SettleDone;

  assign w_L0 = (i5_Ltssm == LTSSM_L0);

  // --------------------------------------------------------------------------
  // Hold / training-timeout timer. Cleared on every state change and on an
  // accepted re-sequence request, so it always counts from the first cycle of
  // the current HOLD or TRAIN stay.
  // --------------------------------------------------------------------------
  assign w_TmrClr  = (state_d != state_q) || w_PerstTake;
  assign w_TmrEn   = (state_q == ST_HOLD) || (state_q == ST_TRAIN);
  assign w_TmrTerm = (state_q == ST_HOLD) ? c_HoldTerm : c_TmoTerm;

  pcie_cycle_timer #(
    .WIDTH (c_TmrW)
  ) u_tmr (
    .i_Clk     (i_Clk125M),
    .i_Rst     (i_Rst),
    .i_Clr     (w_TmrClr),
    .i_Load    (1'b0),
    .i_LoadVal ('0),
    .i_En      (w_TmrEn),
    .i_TermVal (w_TmrTerm),
    .o_Tc      (w_TmrTc)
  );

  // --------------------------------------------------------------------------
  // Settle timer: length of the current unbroken L0 run inside TRAIN. Any
  // cycle outside TRAIN clears it, so every TRAIN entry starts at zero.
  // --------------------------------------------------------------------------
  assign w_SetRun     = (state_q == ST_TRAIN) && w_L0;
  assign w_SettleDone = w_SetRun && w_SetTc;

  pcie_cycle_timer #(
    .WIDTH (c_SetW)
  ) u_settle (
    .i_Clk     (i_Clk125M),
    .i_Rst     (i_Rst),
    .i_Clr     (!w_SetRun),
    .i_Load    (1'b0),
    .i_LoadVal ('0),
    .i_En      (w_SetRun),
    .i_TermVal (c_SetTerm),
    .o_Tc      (w_SetTc)
  );

  // --------------------------------------------------------------------------
  // State / output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clk125M or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= ST_RESET;
      retry_q  <= '0;
      npor_q   <= 1'b0;
      perst_q  <= 1'b0;
      app_q    <= 1'b0;
      linkup_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      npor_q   <= npor_d;
      perst_q  <= perst_d;
      app_q    <= app_d;
      linkup_q <= linkup_d;
      fail_q   <= fail_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Normal transitions first, then the re-sequence request,
  // then PLL loss, so later assignments carry the higher priority.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    w_PerstTake = 1'b0;

    case (state_q)
      ST_RESET:    state_d = ST_WAIT_PLL;
      ST_WAIT_PLL: if (i_PllLocked) state_d = ST_HOLD;
      ST_HOLD:     if (w_TmrTc) state_d = ST_TRAIN;
      ST_TRAIN: begin
        // A settle completing on the timeout cycle still wins.
        if (w_SettleDone) begin
          state_d = ST_LINKUP;
        end else if (w_TmrTc) begin
          retry_d = sat_inc4(retry_q);
          state_d = (retry_q >= c_RetryLast) ? ST_FAIL : ST_HOLD;
        end
      end
      ST_LINKUP:   if (!w_L0) state_d = ST_TRAIN;
      ST_FAIL:     state_d = ST_FAIL;
      default:     state_d = ST_RESET;
    endcase

    if (i_PerstReq && (state_q inside {ST_HOLD, ST_TRAIN, ST_LINKUP, ST_FAIL})) begin
      state_d     = ST_HOLD;
      retry_d     = '0;
      w_PerstTake = 1'b1;
    end

    // PLL loss keeps the retry history so a flaky link still ends in FAIL.
    if (!i_PllLocked && (state_q inside {ST_HOLD, ST_TRAIN, ST_LINKUP})) begin
      state_d     = ST_WAIT_PLL;
      retry_d     = retry_q;
      w_PerstTake = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state, so the registered outputs change on the
  // same edge as the state they belong to.
  // --------------------------------------------------------------------------
  always_comb begin
    npor_d   = 1'b0;
    perst_d  = 1'b0;
    app_d    = 1'b0;
    linkup_d = 1'b0;
    fail_d   = 1'b0;
    case (state_d)
      ST_TRAIN: begin
        npor_d  = 1'b1;
        perst_d = 1'b1;
      end
      ST_LINKUP: begin
        npor_d   = 1'b1;
        perst_d  = 1'b1;
        app_d    = 1'b1;
        linkup_d = 1'b1;
      end
      ST_FAIL:   fail_d = 1'b1;
      default:   ;
    endcase
  end

  assign o_Npor_L     = npor_q;
  assign o_PinPerst_L = perst_q;
  assign o_AppRst_L   = app_q;
  assign o_LinkUp     = linkup_q;
  assign o_Fail       = fail_q;
  assign o3_State     = state_q;
  assign o4_RetryCnt  = retry_q;

endmodule : pcie_link_ctrl

`default_nettype wire

// File: doc/pcie_link_ctrl.md
# pcie_link_ctrl

Reset and link-bring-up sequencer for the PCIe hard-IP design examples (Gen1/Gen2 x4).
- Drives the HIP `npor`, `pin_perst` and application `reset_n` inputs in the correct order; these are currently tied to one board reset.
- Watches the LTSSM until the link settles in L0, retries training on timeout, and reports link-up or failure to the rest of the board design.
- Sits between the board reset/PLL logic and the design-example instance.

## Interface
Parameters:
- PERST_CYCLES, 12500: cycles resets are held after PLL lock (100 us at 125 MHz).
- TRAIN_TIMEOUT, 12500000: cycles allowed in TRAIN to reach stable L0 (100 ms).
- SETTLE_CYCLES, 1024: consecutive L0 cycles required to declare link-up.
- MAX_RETRY, 3: training timeouts tolerated before FAIL; range 1..15.

Ports:
- i_Clk125M, in, 1: sole clock. All inputs are synchronous to it.
- i_Rst, in, 1: asynchronous, active-high reset.
- i_PllLocked, in, 1: reference/transceiver PLL locked.
- i_PerstReq, in, 1: one-cycle pulse requesting a full re-sequence.
- i5_Ltssm, in, 5: HIP LTSSM state. L0 = 5'h0F.
- o_Npor_L, out, 1: to HIP `npor`.
- o_PinPerst_L, out, 1: to HIP `pin_perst`.
- o_AppRst_L, out, 1: to design-example `reset_n`.
- o_LinkUp, out, 1: link trained and stable.
- o_Fail, out, 1: retries exhausted.
- o3_State, out, 3: current state encoding.
- o4_RetryCnt, out, 4: training timeouts since the last sequence start.

## Operation
- All outputs are registered.
- Reset values: o_Npor_L = o_PinPerst_L = o_AppRst_L = 0, o_LinkUp = 0, o_Fail = 0, o3_State = RESET (0), o4_RetryCnt = 0.
- States and encodings: RESET = 0, WAIT_PLL = 1, HOLD = 2, TRAIN = 3, LINKUP = 4, FAIL = 5.
- RESET: all resets asserted. Unconditionally goes to WAIT_PLL on the next cycle.
- WAIT_PLL: all resets asserted, counters cleared. Goes to HOLD when i_PllLocked = 1.
- HOLD: all resets asserted; hold counter increments each cycle.
  - When the counter reaches PERST_CYCLES-1, go to TRAIN.
  - o_Npor_L and o_PinPerst_L rise on that same edge.
- TRAIN: o_Npor_L = o_PinPerst_L = 1, o_AppRst_L = 0.
  - Timeout counter runs from TRAIN entry.
  - Settle counter increments while i5_Ltssm = L0 and clears on any non-L0 cycle.
  - When the settle counter reaches SETTLE_CYCLES-1 with L0 present, go to LINKUP.
  - On timeout (counter reaches TRAIN_TIMEOUT-1):
    - retry count < MAX_RETRY-1: increment retry count, go to HOLD (resets reasserted).
    - retry count = MAX_RETRY-1: increment retry count, go to FAIL.
- LINKUP: all resets released, o_LinkUp = 1.
  - On any non-L0 sample: go to TRAIN. o_LinkUp and o_AppRst_L fall on the next edge. Timeout and settle counters restart. Retry count is unchanged.
- FAIL: all resets asserted, o_Fail = 1. Left only via i_PerstReq or i_Rst.
- Global overrides, in priority order:
  1. i_PllLocked = 0 in HOLD, TRAIN or LINKUP goes to WAIT_PLL, with retry count preserved.
  2. i_PerstReq in any state except RESET/WAIT_PLL goes to HOLD and clears the retry count. It is ignored in WAIT_PLL.
- Simultaneous events in TRAIN: settle-complete beats timeout.
- Counter sizes: hold and timeout counters are $clog2 of their parameter + 1 bits. The retry count saturates at 15.

## Timing
- Release latency: o_Npor_L/o_PinPerst_L rise exactly PERST_CYCLES cycles after the first HOLD cycle.
- Link-up latency: with L0 first sampled at cycle t in TRAIN and held, o_LinkUp = 1 from edge t+SETTLE_CYCLES.
- Link-down latency: o_LinkUp falls one cycle after the first non-L0 sample in LINKUP.
- Timeout: fires on the TRAIN_TIMEOUT-th TRAIN cycle; resets reassert on the following edge.
- i_Rst mid-operation: all outputs take their reset values asynchronously. After deassertion, the FSM restarts from RESET.

## Structure
- Package pcie_link_pkg contains:
  - the state enum with the encodings above;
  - the constant LTSSM_L0 = 5'h0F;
  - default parameter constants.
- One sub-module, pcie_cycle_timer: a loadable up-counter with clear and a terminal-count flag. It is instantiated twice (hold/timeout shared, settle).

## Test plan
All scenarios use PERST_CYCLES=8, TRAIN_TIMEOUT=64, SETTLE_CYCLES=4, MAX_RETRY=2.
- Nominal bring-up: lock at cycle 5, L0 from TRAIN entry → o_Npor_L rises 8 cycles after HOLD entry; o_LinkUp and o_AppRst_L rise 4 cycles later; o4_RetryCnt = 0.
- Flapping L0: pattern L0,L0,L0,non-L0,L0×4 → no link-up until the final 4-cycle run completes.
- Timeouts: LTSSM stuck at 5'h02 → first timeout gives o4_RetryCnt = 1 and a HOLD re-entry; second timeout gives o_Fail = 1 with resets low; then i_PerstReq gives o_Fail = 0, o4_RetryCnt = 0, state = HOLD.
- Link drop: in LINKUP drive LTSSM non-L0 for 1 cycle → o_LinkUp = 0 next edge, state = TRAIN, o_Npor_L stays 1.
- PLL loss: drop i_PllLocked in LINKUP → state = WAIT_PLL and all resets low next edge; relock → full sequence repeats.
- Async reset: assert i_Rst mid-HOLD between edges → outputs reach reset values before the next edge; the sequence restarts cleanly.
